// File: rtl/cnt_interval_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : cnt_interval_arb_if
// Brief    : Request/grant/done bundle between two counter clients and the
//            shared interval counter arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface cnt_interval_arb_if #(
    parameter int CNT_W = 6
);
    logic             req0;
    logic [CNT_W-1:0] len0;
    logic             req1;
    logic [CNT_W-1:0] len1;
    logic             hold;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic             busy;
    logic [CNT_W-1:0] cnt;

    // Requesting side: drives requests, lengths and the global pause.
    modport master (
        output req0, len0, req1, len1, hold,
        input  gnt0, gnt1, done0, done1, busy, cnt
    );

    // Arbiter side.
    modport slave (
        input  req0, len0, req1, len1, hold,
        output gnt0, gnt1, done0, done1, busy, cnt
    );
endinterface
`default_nettype wire

// File: rtl/cnt_interval_arb.sv
`default_nettype none
// ============================================================================
// Module   : cnt_interval_arb
// Brief    : Round-robin arbiter sharing one interval counter between two
//            requesters, with global hold and one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module cnt_interval_arb #(
    parameter int CNT_W = 6
) (
    input  wire                    clk,
    input  wire                    reset,
    cnt_interval_arb_if.slave      bus
);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_RUN  = 2'd1;
    localparam logic [1:0] C_DONE = 2'd2;

    logic [1:0]       r_state;
    logic             r_owner;
    logic             r_last;
    logic [CNT_W-1:0] r_tgt;
    logic [CNT_W-1:0] r_cnt;

    logic [1:0]       w_state_nxt;
    logic             w_owner_nxt;
    logic             w_last_nxt;
    logic [CNT_W-1:0] w_tgt_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic             w_win0;
    logic             w_win1;
    logic             w_own_req;
    logic [CNT_W-1:0] w_cnt_inc;

    // On a tie the requester that did not win last time gets the counter.
    assign w_win0    = bus.req0 && (!bus.req1 || r_last);
    assign w_win1    = bus.req1 && !w_win0;
    assign w_own_req = r_owner ? bus.req1 : bus.req0;
    assign w_cnt_inc = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= C_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_tgt   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_tgt   <= w_tgt_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_tgt_nxt   = r_tgt;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            C_IDLE: begin
                if (w_win0 || w_win1) begin
                    w_state_nxt = C_RUN;
                    w_owner_nxt = w_win1;
                    w_last_nxt  = w_win1;
                    w_tgt_nxt   = w_win1 ? bus.len1 : bus.len0;
                    w_cnt_nxt   = '0;
                end
            end
            C_RUN: begin
                // An owner dropping its request aborts even while paused.
                if (!w_own_req) begin
                    w_state_nxt = C_IDLE;
                end else if (!bus.hold) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == r_tgt) begin
                        w_state_nxt = C_DONE;
                    end
                end
            end
            C_DONE: begin
                w_state_nxt = C_IDLE;
            end
            default: begin
                w_state_nxt = C_IDLE;
            end
        endcase
    end

    assign bus.busy  = (r_state != C_IDLE);
    assign bus.gnt0  = (r_state != C_IDLE) && !r_owner;
    assign bus.gnt1  = (r_state != C_IDLE) &&  r_owner;
    assign bus.done0 = (r_state == C_DONE) && !r_owner;
    assign bus.done1 = (r_state == C_DONE) &&  r_owner;
    assign bus.cnt   = r_cnt;

endmodule
`default_nettype wire

// File: doc/cnt_interval_arb.md
# cnt_interval_arb

Shares a single 6-bit interval counter between two requesters. Each requester asks for a run of `len` counts. The block grants the counter round-robin, clears and runs it, honours a global `hold` pause, and returns a one-cycle `done` to the owner. It sits between requesting control FSMs and the counting datapath, replacing direct `cnt_en` driving by each client.

## Interface
- `CNT_W`, default 6: counter and length width.
- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `req0`, input, 1: requester 0 wants the counter; held high until `done0`.
- `len0`, input, CNT_W: requester 0 run length; 0 means 2^CNT_W.
- `req1`, input, 1: requester 1 request.
- `len1`, input, CNT_W: requester 1 run length.
- `hold`, input, 1: pauses counting while high.
- `gnt0`, output, 1: counter owned by requester 0.
- `gnt1`, output, 1: counter owned by requester 1.
- `done0`, output, 1: one-cycle completion pulse to requester 0.
- `done1`, output, 1: one-cycle completion pulse to requester 1.
- `busy`, output, 1: state is not IDLE.
- `cnt`, output, CNT_W: live counter value.

## Operation
- **States:** IDLE, RUN, DONE. All outputs are registered or decoded from registered state.
- **Reset:**
  - State IDLE, `cnt` = 0, `gnt*` = `done*` = `busy` = 0.
  - Round-robin pointer `last` = 1, so requester 0 wins the first tie.
- **IDLE:**
  - If only one `req` is high, grant it.
  - If both are high, grant the requester other than `last`.
  - On grant: latch `len` of the winner into `tgt`, set `cnt` = 0, update `last`, go to RUN.
  - `hold` is ignored in IDLE.
- **RUN:**
  - While owner `req` = 1 and `hold` = 0, `cnt` increments modulo 2^CNT_W.
  - Terminal increment: the one where `cnt + 1 == tgt` (CNT_W-bit compare). Go to DONE; `cnt` now equals `tgt` (0 for `tgt` = 0 after 64 counts).
  - `hold` = 1: `cnt` and state frozen.
  - Owner `req` = 0 (abort): go to IDLE next edge. No `done`; `cnt` holds its value.
  - The other requester's `req` and all `len` changes are ignored.
- **DONE:**
  - The owner's `done` is high for exactly this one cycle; the grant stays high.
  - `hold` and `req` are ignored.
  - Unconditionally go to IDLE.
- **After DONE or abort:**
  - `gnt` deasserts and `cnt` holds its last value until the next grant.
  - A requester keeping `req` high after `done` is treated as a new request and loses any tie to the other requester.
- **Invariants:**
  - `gnt0` and `gnt1` are never both 1.
  - `done0` and `done1` are never both 1.
  - `doneX` implies `gntX`.

## Timing
- `req` high in IDLE at cycle t gives `gnt` = 1, `busy` = 1, `cnt` = 0 at cycle t+1.
- `len` = N, no hold:
  - `cnt` = k at t+1+k.
  - DONE state and `done` = 1 at t+1+N.
  - `gnt`/`busy` = 0 at t+2+N.
  - Earliest next grant at t+3+N.
- Each cycle with `hold` = 1 during RUN delays all subsequent events by one cycle.
- Abort: owner `req` low at cycle r in RUN gives `gnt` = 0 at r+1 and next grant earliest at r+2.
- Asynchronous `reset` mid-RUN or mid-DONE: all outputs are 0 immediately, with no `done` pulse. After deassertion, the first grant occurs on the first edge after deassertion that sees `req` in IDLE.

## Test plan
- **Reset:** assert `reset` asynchronously mid-RUN. Required: all outputs 0 immediately; after release, `req0` = 1, `len0` = 5 gives `gnt0` on the next edge.
- **Single run:** `req0` = 1, `len0` = 5, no hold. Required:
  - `gnt0` one cycle later.
  - `cnt` steps 0..5.
  - `done0` high exactly one cycle, coincident with `cnt` = 5.
  - `gnt0` low the following cycle.
- **Tie and round-robin:** both `req` high from reset, `len0` = 3, `len1` = 2, both held. Required grant order 0, 1, 0, 1, with `done` pulses on matching owners and never overlapping grants.
- **Hold:** `len1` = 4, `hold` pulsed for 3 cycles after `cnt` = 2. Required:
  - `cnt` frozen at 2 for 3 cycles.
  - `done1` arrives 3 cycles later than the unpaused case.
- **Wrap / zero length:** `len0` = 0. Required: `cnt` counts 0..63 then wraps to 0, with `done0` at `cnt` = 0 exactly 64 cycles after the grant.
- **Abort and late length change:**
  - Change `len0` from 10 to 2 after the grant. Required: run still ends at `cnt` = 10.
  - Drop `req0` at `cnt` = 4. Required: `gnt0` low next cycle, no `done0`, `cnt` holds 4, and a pending `req1` is granted the cycle after.
